// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart TX word interface among NumReq requesters.
// Arbitration is round-robin at message granularity: a winner keeps the lock
// until a word flagged last has fully left the line.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a lock-hold watchdog that
// releases a stalled lock after TimeoutTicks idle cycles and pulses msg_abort.
// The checker module below holds the design's invariants as assertions.

module uart_tx_arbiter_chk #(
  parameter int NumReq       = 4,
  parameter int DataBits     = 8,
  parameter int TimeoutTicks = 1000
) (
  input logic                clk,
  input logic                reset_n,
  input logic [NumReq-1:0]   req_ready,
  input logic                tx_start,
  input logic                tx_active,
  input logic [DataBits-1:0] tx_word,
  input logic                grant_valid,
  input logic                msg_done,
  input logic                msg_abort
);

  localparam bit ParamsOk = (NumReq >= 2) && (NumReq <= 16) && (DataBits >= 1) &&
                            (TimeoutTicks >= 1);

  a_params_ok: assert property (@(posedge clk) ParamsOk);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));

  a_start_needs_grant: assert property (@(posedge clk) disable iff (!reset_n)
    tx_start |-> grant_valid);

  a_done_releases: assert property (@(posedge clk) disable iff (!reset_n)
    (msg_done || msg_abort) |-> !grant_valid);

  a_done_abort_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(msg_done && msg_abort));

  a_start_held: assert property (@(posedge clk) disable iff (!reset_n)
    (tx_start && !tx_active) |=> (tx_start && $stable(tx_word)));

endmodule

module uart_tx_arbiter #(
  parameter int  NumReq       = 4,
  parameter int  DataBits     = 8,
  parameter int  TimeoutTicks = 1000,
  localparam int IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NumReq-1:0]            req_valid,
  input  logic [NumReq*DataBits-1:0]   req_word,
  input  logic [NumReq-1:0]            req_last,
  output logic [NumReq-1:0]            req_ready,
  output logic                         grant_valid,
  output logic [IdW-1:0]               grant_id,
  output logic                         msg_done,
  output logic                         msg_abort,
  output logic                         tx_start,
  output logic [DataBits-1:0]          tx_word,
  input  logic                         tx_active,
  input  logic                         tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_BUSY   = 3'd2,
    S_DRAIN  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t              state_r;
  logic [DataBits-1:0] word_r;
  logic                last_r;
  logic [IdW-1:0]      grant_id_r;
  logic [IdW-1:0]      last_id_r;
  logic                tx_start_r;
  logic                grant_valid_r;
  logic                msg_done_r;

  logic                found_s;
  logic [IdW-1:0]      winner_s;
  logic [IdW-1:0]      scan_s;
  logic                hit_s;
  logic [IdW-1:0]      sel_id_s;
  logic [DataBits-1:0] sel_word_s;
  logic                sel_last_s;
  logic [NumReq-1:0]   req_ready_s;
  logic                xfer_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TmoW = (TimeoutTicks > 1) ? $clog2(TimeoutTicks) : 1;
  logic [TmoW-1:0] tmo_cnt_r;
  logic            msg_abort_r;
`endif

  // Round-robin scan: first valid requester after the last message owner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IdW{1'b0}};
    scan_s   = last_id_r;
    hit_s    = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      scan_s   = (scan_s == IdW'(NumReq - 1)) ? {IdW{1'b0}} : (scan_s + IdW'(1));
      hit_s    = req_valid[scan_s] && !found_s;
      winner_s = hit_s ? scan_s : winner_s;
      found_s  = found_s | hit_s;
    end
  end

  // Word/last mux: the arbitration winner when idle, the lock holder otherwise.
  always_comb begin
    sel_id_s   = (state_r == S_IDLE) ? winner_s : grant_id_r;
    sel_word_s = {DataBits{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      sel_word_s = (sel_id_s == IdW'(i)) ? req_word[i*DataBits +: DataBits] : sel_word_s;
    end
    sel_last_s = req_last[sel_id_s];
  end

  // Ready is combinational so a requester can transfer in the grant cycle.
  always_comb begin
    req_ready_s = {NumReq{1'b0}};
    case (state_r)
      S_IDLE:   req_ready_s[winner_s]   = found_s;
      S_LOCKED: req_ready_s[grant_id_r] = 1'b1;
      default:  req_ready_s             = {NumReq{1'b0}};
    endcase
    xfer_s = |(req_ready_s & req_valid);
  end

  // Message-level FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      word_r        <= {DataBits{1'b0}};
      last_r        <= 1'b0;
      grant_id_r    <= {IdW{1'b0}};
      last_id_r     <= IdW'(NumReq - 1);
      tx_start_r    <= 1'b0;
      grant_valid_r <= 1'b0;
      msg_done_r    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt_r     <= {TmoW{1'b0}};
      msg_abort_r   <= 1'b0;
`endif
    end else begin
      msg_done_r <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      msg_abort_r <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (xfer_s) begin
            word_r        <= sel_word_s;
            last_r        <= sel_last_s;
            grant_id_r    <= winner_s;
            grant_valid_r <= 1'b1;
            tx_start_r    <= 1'b1;
            state_r       <= S_START;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_START: begin
          // Hold tx_start and the word until the uart reports it has begun.
          if (tx_active) begin
            tx_start_r <= 1'b0;
            state_r    <= S_BUSY;
          end else begin
            state_r <= S_START;
          end
        end
        S_BUSY: begin
          if (tx_done) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_BUSY;
          end
        end
        S_DRAIN: begin
          // tx_active lingers one cycle after tx_done; wait it out so the
          // next word's start is not mistaken for the current one.
          if (!tx_active) begin
            if (last_r) begin
              msg_done_r    <= 1'b1;
              grant_valid_r <= 1'b0;
              last_id_r     <= grant_id_r;
              state_r       <= S_IDLE;
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
              tmo_cnt_r <= {TmoW{1'b0}};
`endif
              state_r <= S_LOCKED;
            end
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_LOCKED: begin
          if (xfer_s) begin
            word_r     <= sel_word_s;
            last_r     <= sel_last_s;
            tx_start_r <= 1'b1;
            state_r    <= S_START;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TmoW'(TimeoutTicks - 1)) begin
            // Stalled owner: release the lock; the partial message is left
            // unterminated on the line.
            msg_abort_r   <= 1'b1;
            grant_valid_r <= 1'b0;
            last_id_r     <= grant_id_r;
            state_r       <= S_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TmoW'(1);
          end
`else
          else begin
            state_r <= S_LOCKED;
          end
`endif
        end
        default: begin
          tx_start_r    <= 1'b0;
          grant_valid_r <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_s;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign msg_done    = msg_done_r;
  assign tx_start    = tx_start_r;
  assign tx_word     = word_r;
`ifdef UART_ARB_TIMEOUT_EN
  assign msg_abort   = msg_abort_r;
`else
  assign msg_abort   = 1'b0;
`endif

  uart_tx_arbiter_chk #(
    .NumReq       (NumReq),
    .DataBits     (DataBits),
    .TimeoutTicks (TimeoutTicks)
  ) u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_ready   (req_ready_s),
    .tx_start    (tx_start_r),
    .tx_active   (tx_active),
    .tx_word     (word_r),
    .grant_valid (grant_valid_r),
    .msg_done    (msg_done_r),
    .msg_abort   (msg_abort)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a small uart model
// with a cts_n gate, and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NumReq   = 4;
  localparam int DataBits = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TmoTicks = 50;
`else
  localparam int TmoTicks = 1000;
`endif
  localparam int KWord  = 0;
  localparam int KDone  = 1;
  localparam int KAbort = 2;

  logic                       clk;
  logic                       reset_n;
  logic                       cts_n;
  logic [NumReq-1:0]          req_valid;
  logic [NumReq*DataBits-1:0] req_word;
  logic [NumReq-1:0]          req_last;
  logic [NumReq-1:0]          req_ready;
  logic                       grant_valid;
  logic [1:0]                 grant_id;
  logic                       msg_done;
  logic                       msg_abort;
  logic                       tx_start;
  logic [DataBits-1:0]        tx_word;
  logic                       tx_active;
  logic                       tx_done;

  typedef struct {
    int kind;
    int id;
    int word;
  } ev_t;

  ev_t               exp_q[$];
  logic [DataBits:0] rq    [NumReq][$];   // {last, word} per requester
  logic [DataBits:0] stage [NumReq][$];
  int                errors = 0;
  int                checks = 0;
  int                model_last = NumReq - 1;
  int                uphase;
  int                ucnt;
  logic [NumReq-1:0] xfer;

  uart_tx_arbiter #(
    .NumReq       (NumReq),
    .DataBits     (DataBits),
    .TimeoutTicks (TmoTicks)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_word    (req_word),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .msg_done    (msg_done),
    .msg_abort   (msg_abort),
    .tx_start    (tx_start),
    .tx_word     (tx_word),
    .tx_active   (tx_active),
    .tx_done     (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void push_ev(input int kind, input int id, input int word);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.word = word;
    exp_q.push_back(e);
  endfunction

  function automatic bit rq_busy();
    bit b = 1'b0;
    for (int i = 0; i < NumReq; i++) if (rq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Reference model: whole staged batch is presented at once while the
  // arbiter is idle, so the line order is fixed by message-level round robin.
  task automatic issue();
    logic [DataBits:0] pend [NumReq][$];
    logic [DataBits:0] it;
    int id;
    bit fin;
    for (int i = 0; i < NumReq; i++) pend[i] = stage[i];
    while (1) begin
      id = -1;
      for (int k = 1; k <= NumReq; k++) begin
        int c;
        c = (model_last + k) % NumReq;
        if (id < 0 && pend[c].size() > 0) id = c;
      end
      if (id < 0) break;
      fin = 1'b0;
      while (pend[id].size() > 0 && !fin) begin
        it = pend[id].pop_front();
        push_ev(KWord, id, int'(it[DataBits-1:0]));
        fin = it[DataBits];
      end
      if (fin) begin
        push_ev(KDone, id, 0);
        model_last = id;
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        push_ev(KAbort, id, 0);
        model_last = id;
`else
        break;
`endif
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      foreach (stage[i][j]) rq[i].push_back(stage[i][j]);
      stage[i].delete();
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || grant_valid || uphase != 0 || rq_busy()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_in_budget"}, 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    model_last = NumReq - 1;
    reset_n = 1'b1;
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d id=%0d required=no event", kind, grant_id);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_id", 32'(grant_id), e.id);
      if (kind == KWord) begin
        check("tx_word", 32'(tx_word), e.word);
        check("grant_valid_at_start", 32'(grant_valid), 1);
      end else begin
        check("grant_valid_after_end", 32'(grant_valid), 0);
      end
    end
  endtask

  // Requesters: pop on transfer, present the queue head after each edge.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_word  = '0;
    xfer      = '0;
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NumReq; i++) begin
        if (!reset_n) rq[i].delete();
        else if (xfer[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_word[i*DataBits +: DataBits] = rq[i][0][DataBits-1:0];
          req_last[i] = rq[i][0][DataBits];
        end else begin
          req_valid[i] = 1'b0;
          req_word[i*DataBits +: DataBits] = DataBits'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
    end
  end

  // uart model: start on tx_start when clear to send, random word length,
  // tx_done pulse, then tx_active held one more cycle.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    uphase    = 0;
    ucnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        uphase = 0; tx_active = 1'b0; tx_done = 1'b0;
      end else begin
        case (uphase)
          0: if (tx_start && !cts_n) begin
               tx_active = 1'b1; ucnt = $urandom_range(0, 3); uphase = 1;
             end
          1: if (ucnt == 0) begin tx_done = 1'b1; uphase = 2; end else ucnt--;
          2: begin tx_done = 1'b0; uphase = 3; end
          3: begin tx_active = 1'b0; uphase = 0; end
          default: uphase = 0;
        endcase
      end
    end
  end

  // Monitor: every word start, msg_done and msg_abort is matched in order.
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start = 1'b0;
      end else begin
        if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
        if (tx_start && !prev_start) take(KWord);
        if (msg_done) take(KDone);
        if (msg_abort) take(KAbort);
        prev_start = tx_start;
      end
    end
  end

  initial begin
    int n;
    int bad;
    int held;
    logic [DataBits-1:0] cap;
    reset_n = 1'b0;
    cts_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_word", 32'(tx_word), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_msg_done", 32'(msg_done), 0);
    check("rst_msg_abort", 32'(msg_abort), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-word message from requester 0.
    stage[0].push_back({1'b0, 8'h41});
    stage[0].push_back({1'b1, 8'h42});
    issue();
    wait_quiet("two_word", 300);

    // All requesters streaming single-word messages.
    for (int i = 0; i < NumReq; i++)
      for (int m = 0; m < 3; m++) stage[i].push_back({1'b1, 8'($urandom)});
    issue();
    wait_quiet("all_single", 1000);

    // Requester 1 holds a 3-word message while requester 2 waits.
    stage[1].push_back({1'b0, 8'h10});
    stage[1].push_back({1'b0, 8'h11});
    stage[1].push_back({1'b1, 8'h12});
    stage[2].push_back({1'b1, 8'h20});
    issue();
    wait_quiet("lock_hold", 500);

    // Random batches of random-length messages.
    repeat (4) begin
      for (int i = 0; i < NumReq; i++) begin
        int nm;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int w = 0; w < len; w++) stage[i].push_back({1'(w == len - 1), 8'($urandom)});
        end
      end
      issue();
      wait_quiet("random", 3000);
    end

    // uart not clear to send: start must be held with a stable word.
    cts_n = 1'b1;
    stage[0].push_back({1'b1, 8'h5A});
    issue();
    n = 0;
    while (!tx_start && n < 50) begin @(negedge clk); n++; end
    check("cts_start_seen", 32'(tx_start), 1);
    cap = tx_word;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_start !== 1'b1 || tx_word !== cap || req_ready !== '0) bad++;
    end
    check("cts_hold_bad_cycles", bad, 0);
    cts_n = 1'b0;
    wait_quiet("cts_release", 200);

    // Asynchronous reset while a word is on the line.
    stage[1].push_back({1'b0, 8'h77});
    stage[1].push_back({1'b1, 8'h78});
    issue();
    n = 0;
    while (!(tx_active && !tx_start) && n < 100) begin @(negedge clk); n++; end
    check("busy_reached", 32'(tx_active && !tx_start), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_tx_start", 32'(tx_start), 0);
    check("async_rst_grant_valid", 32'(grant_valid), 0);
    check("async_rst_msg_done", 32'(msg_done), 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    model_last = NumReq - 1;
    reset_n = 1'b1;
    stage[2].push_back({1'b1, 8'hA2});
    stage[0].push_back({1'b1, 8'hA0});
    issue();
    wait_quiet("after_reset", 300);

    // Requester 3 stalls after a non-last word.
    stage[3].push_back({1'b0, 8'hC3});
    issue();
    n = 0;
    while (!(grant_valid && req_ready[3]) && n < 100) begin @(negedge clk); n++; end
    check("locked_reached", 32'(grant_valid && req_ready[3]), 1);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!msg_abort && n < TmoTicks + 20) begin @(negedge clk); n++; end
    check("abort_delay", n, TmoTicks);
`else
    held = 0;
    repeat (1100) begin
      @(negedge clk);
      if (grant_valid && grant_id == 2'd3 && req_ready == 4'b1000 && !msg_abort) held++;
    end
    check("lock_held_cycles", held, 1100);
    do_reset();
`endif
    stage[1].push_back({1'b1, 8'hB1});
    stage[0].push_back({1'b1, 8'hB0});
    issue();
    wait_quiet("after_release", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single TX FIFO interface of the `uart` block among NumReq requesters.
- Arbitration is round-robin at message granularity. Once a requester wins, it keeps the UART until it sends a word flagged `last`. This keeps delimited messages (e.g. "command;") from interleaving.
- Sits between the requester logic and `uart`: it drives `tx_start`/`tx_word` and monitors `tx_active`/`tx_done`.

Parameters:
- NumReq, 4, number of requesters (2..16).
- DataBits, 8, word width; must match the `uart` instance.
- TimeoutTicks, 1000, lock-hold watchdog in clk cycles; used only with UART_ARB_TIMEOUT_EN (>=1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NumReq  per-requester word valid.
- req_word  in  NumReq*DataBits  requester i word at [i*DataBits +: DataBits].
- req_last  in  NumReq  word is the final word of its message.
- req_ready  out  NumReq  word transfer occurs on the clk edge where req_valid[i] & req_ready[i].
- grant_valid  out  1  a requester holds the UART lock.
- grant_id  out  max(1,clog2(NumReq))  index of the lock holder.
- msg_done  out  1  one-cycle pulse when the last word of a message finishes on the line.
- msg_abort  out  1  one-cycle pulse on watchdog release (optional feature).
- tx_start  out  1  to uart.tx_start.
- tx_word  out  DataBits  to uart.tx_word.
- tx_active  in  1  from uart.tx_active.
- tx_done  in  1  from uart.tx_done.

Behaviour:
- Async reset (reset_n=0):
  - State goes to S_IDLE immediately.
  - tx_start=0, tx_word=0, grant_valid=0, grant_id=0, msg_done=0, msg_abort=0.
  - Round-robin pointer last_id=NumReq-1, so requester 0 has first priority.
  - Reset mid-transfer abandons the word. Requesters must not assume delivery.
- Registers: state, word_reg, last_reg, grant_id, last_id, timeout counter.
- req_ready is combinational from state and req_valid. All other outputs are registered.
- S_IDLE:
  - Winner = first i with req_valid[i]=1, scanning last_id+1, last_id+2, ... modulo NumReq.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - On the edge: latch word_reg and last_reg, set grant_id=winner and grant_valid=1, go to S_START.
  - With no valid requester, stay in S_IDLE.
- S_START:
  - tx_start=1 and tx_word=word_reg; both held stable.
  - When tx_active=1, go to S_BUSY, with tx_start=0 from the next cycle.
  - If cts_n is deasserted, S_START holds indefinitely.
- S_BUSY: wait for tx_done=1, then go to S_DRAIN.
- S_DRAIN:
  - Wait for tx_active=0. `uart` holds tx_active for one cycle after tx_done; this state prevents a false start detect.
  - Then, if last_reg=1: pulse msg_done, set grant_valid=0, last_id=grant_id, go to S_IDLE.
  - Otherwise go to S_LOCKED.
- S_LOCKED:
  - req_ready[grant_id]=1; all other requesters are ignored.
  - On transfer: latch word and last, go to S_START.
- Latency:
  - req transfer to tx_start=1: 1 cycle.
  - tx_done to next req_ready: at least 2 cycles.
- Simultaneous requests: exactly one grant per arbitration, never two req_ready bits high.
- req_valid dropping before transfer: no effect, and no grant is taken.
- Single-word message (last=1 on the first word): the lock is released after that word.
- last_id updates only on message completion or abort, so each requester gets one message per round.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to S_LOCKED and increments each cycle in S_LOCKED without a transfer.
  - At TimeoutTicks: pulse msg_abort, set grant_valid=0, last_id=grant_id, go to S_IDLE.
  - The partial message is not terminated on the line.
- Undefined:
  - The lock is held indefinitely.
  - msg_abort is tied to 0 and no counter is synthesized.

Test Plan:
- Reset, then req_valid=4'b0001 with words 0x41,0x42 (last on 0x42) and a `uart` model:
  - tx_start pulses twice, once per word.
  - tx_word is 0x41 then 0x42.
  - msg_done pulses once, after the second tx_done.
  - grant_id=0 throughout; grant_valid falls with msg_done.
- req_valid=4'b1111, each requester sending 1-word messages continuously:
  - Grant order is 0,1,2,3,0,...
  - No two req_ready bits are ever high together.
- Requester 1 holds a 3-word message while requester 2 requests:
  - req_ready[2] stays 0 until msg_done.
  - Requester 2 is granted next and no words interleave on tx_word.
- Hold cts_n high (`uart` never starts) for 500 cycles:
  - tx_start stays 1 with tx_word stable.
  - No req_ready is asserted.
  - After cts_n falls, the transfer completes normally.
- Assert reset_n=0 asynchronously while in S_BUSY:
  - tx_start, grant_valid, msg_done are 0 within the same cycle.
  - After release, arbitration restarts at requester 0.
- With UART_ARB_TIMEOUT_EN and TimeoutTicks=50, requester 3 sends one non-last word then drops valid:
  - msg_abort pulses 50 cycles after entry to S_LOCKED.
  - Requester 0 is granted next.
  - Without the macro, the lock is held for more than 1000 cycles.
